// File: rtl/watch_pkg.sv
// Shared constants for the watch control path: mode encoding and ms-per-second.
// Imported by watch_set_cu and watch_btn_debounce.
package watch_pkg;

  localparam logic [1:0] MODE_RUN  = 2'd0;
  localparam logic [1:0] MODE_HOUR = 2'd1;
  localparam logic [1:0] MODE_MIN  = 2'd2;
  localparam logic [1:0] MODE_SEC  = 2'd3;

  localparam int MS_PER_SEC = 1000;

  // Mode sequence RUN -> HOUR -> MIN -> SEC -> RUN is a plain 2-bit wrap.
  function automatic logic [1:0] next_mode(input logic [1:0] m);
    return m + 2'd1;
  endfunction

endpackage

// File: rtl/watch_btn_debounce.sv
// One button: 2-flop synchronizer, ms-tick debounce counter, debounced level, rising-edge pulse.
// o_level and o_press update together, one clk after the deciding ms tick.
module watch_btn_debounce
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_MS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick_1ms,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int CW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;
  logic          w_done;

  assign w_done = (r_cnt == CW'(DEBOUNCE_MS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (i_tick_1ms) begin
        if (r_sync2 == r_level) begin
          r_cnt <= '0;
        end else if (w_done) begin
          r_cnt   <= '0;
          r_level <= ~r_level;
          // Only the 0->1 flip is a press; releases produce no pulse.
          r_press <= ~r_level;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/watch_set_cu.sv
// Time-set control: debounced MODE/UP buttons drive a RUN/SET_HOUR/SET_MIN/SET_SEC FSM and 1-clk up pulses.
// Optional hold-to-repeat on UP is built only when WATCH_AUTO_REPEAT_EN is defined.
module watch_set_cu
  import watch_pkg::*;
#(
  parameter int SYS_CLK_HZ  = 100_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int HOLD_MS     = 500,
  parameter int REPEAT_MS   = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  output logic       o_up_sec,
  output logic       o_up_min,
  output logic       o_up_hour,
  output logic [1:0] o_mode,
  output logic       o_set_active
);

  localparam int PRESC = SYS_CLK_HZ / MS_PER_SEC;
  localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [PW-1:0] r_presc;
  logic          w_tick;
  logic          w_mode_lvl;
  logic          w_mode_press;
  logic          w_up_lvl;
  logic          w_up_press;
  logic          w_rep_fire;
  logic          w_fire;
  logic          w_unused;
  logic [1:0]    r_mode;
  logic [1:0]    w_mode_nxt;
  logic          w_up_sec;
  logic          w_up_min;
  logic          w_up_hour;
  logic          r_up_sec;
  logic          r_up_min;
  logic          r_up_hour;

  assign w_tick = (r_presc == PW'(PRESC - 1));

  always_ff @(posedge clk) begin
    if (rst || w_tick) r_presc <= '0;
    else               r_presc <= r_presc + 1'b1;
  end

  watch_btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_mode (
    .clk        (clk),
    .rst        (rst),
    .i_tick_1ms (w_tick),
    .i_btn      (i_btn_mode),
    .o_level    (w_mode_lvl),
    .o_press    (w_mode_press)
  );

  watch_btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_up (
    .clk        (clk),
    .rst        (rst),
    .i_tick_1ms (w_tick),
    .i_btn      (i_btn_up),
    .o_level    (w_up_lvl),
    .o_press    (w_up_press)
  );

`ifdef WATCH_AUTO_REPEAT_EN
  localparam int HW = $clog2(HOLD_MS + 1);
  localparam int RW = (REPEAT_MS > 1) ? $clog2(REPEAT_MS) : 1;

  logic          r_armed;
  logic [HW-1:0] r_hold_cnt;
  logic [RW-1:0] r_rep_cnt;
  logic          w_hold_done;

  assign w_hold_done = (r_hold_cnt == HW'(HOLD_MS));
  assign w_rep_fire  = r_armed && w_tick && !w_mode_press &&
                       ((r_hold_cnt == HW'(HOLD_MS - 1)) ||
                        (w_hold_done && (r_rep_cnt == RW'(REPEAT_MS - 1))));

  // Arming happens only on a clean UP press in a SET state; a MODE press or release disarms.
  always_ff @(posedge clk) begin
    if (rst || w_mode_press || !w_up_lvl) begin
      r_armed    <= 1'b0;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
    end else if (w_up_press && (r_mode != MODE_RUN)) begin
      r_armed    <= 1'b1;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
    end else if (r_armed && w_tick) begin
      if (!w_hold_done)                           r_hold_cnt <= r_hold_cnt + 1'b1;
      else if (r_rep_cnt == RW'(REPEAT_MS - 1))   r_rep_cnt  <= '0;
      else                                        r_rep_cnt  <= r_rep_cnt + 1'b1;
    end
  end

  assign w_unused = w_mode_lvl;
`else
  assign w_rep_fire = 1'b0;
  assign w_unused   = w_mode_lvl ^ w_up_lvl;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_mode <= MODE_RUN;
    else     r_mode <= w_mode_nxt;
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (w_mode_press) w_mode_nxt = next_mode(r_mode);
  end

  // MODE wins a same-clk collision, so the UP press is swallowed.
  assign w_fire = (w_up_press && !w_mode_press) || w_rep_fire;

  always_comb begin
    w_up_sec  = 1'b0;
    w_up_min  = 1'b0;
    w_up_hour = 1'b0;
    case (r_mode)
      MODE_HOUR: w_up_hour = w_fire;
      MODE_MIN:  w_up_min  = w_fire;
      MODE_SEC:  w_up_sec  = w_fire;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_up_sec  <= 1'b0;
      r_up_min  <= 1'b0;
      r_up_hour <= 1'b0;
    end else begin
      r_up_sec  <= w_up_sec;
      r_up_min  <= w_up_min;
      r_up_hour <= w_up_hour;
    end
  end

  assign o_up_sec     = r_up_sec;
  assign o_up_min     = r_up_min;
  assign o_up_hour    = r_up_hour;
  assign o_mode       = r_mode;
  assign o_set_active = (r_mode != MODE_RUN);

endmodule
